// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit between the MEM stage and an
// sram-like data port with split address/data handshakes. Misaligned accesses
// are answered with an error and never reach the bus; cancel kills the access
// and drains any data phase the bus still owes.
module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              cancel,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_strb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic [31:0]       data_rdata,
    input  logic              data_raddr_ok,
    input  logic              data_waddr_ok,
    input  logic              data_rdata_ok,
    input  logic              data_wdata_ok,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic                wr_reg;
    logic                uns_reg;
    logic [1:0]          size_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [3:0]          strb_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         rdata_reg;
    logic                err_reg;

    logic                accept;
    logic [1:0]          in_size;
    logic                misaligned;
    logic [3:0]          in_strb;
    logic [31:0]         in_wdata;
    logic                addr_ok;
    logic                data_ok;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [31:0]         load_ext;

    // Decode the incoming request: reserved size 3 is folded into word.
    always_comb begin
        in_size    = (req_op[1:0] == 2'd3) ? 2'd2 : req_op[1:0];
        misaligned = ((in_size == 2'd1) && req_addr[0]) ||
                     ((in_size == 2'd2) && (req_addr[1:0] != 2'b00));
        in_strb    = 4'b1111;
        in_wdata   = req_wdata;
        case (in_size)
            2'd0: begin
                in_strb  = 4'b0001 << req_addr[1:0];
                in_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                in_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                in_strb  = 4'b1111;
                in_wdata = req_wdata;
            end
        endcase
    end

    assign accept  = (state_reg == IDLE) && req_valid && !cancel;
    assign addr_ok = wr_reg ? data_waddr_ok : data_raddr_ok;
    assign data_ok = wr_reg ? data_wdata_ok : data_rdata_ok;

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        byte_v = data_rdata[7:0];
        case (addr_reg[1:0])
            2'd0: byte_v = data_rdata[7:0];
            2'd1: byte_v = data_rdata[15:8];
            2'd2: byte_v = data_rdata[23:16];
            default: byte_v = data_rdata[31:24];
        endcase
        half_v = addr_reg[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (size_reg)
            2'd0:    load_ext = {{24{byte_v[7] & ~uns_reg}}, byte_v};
            2'd1:    load_ext = {{16{half_v[15] & ~uns_reg}}, half_v};
            default: load_ext = data_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic; a data_ok coinciding with cancel in WAIT is consumed
    // directly so DRAIN never waits for a handshake that already happened.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = misaligned ? RESP : REQ;
            REQ: begin
                if (addr_ok)     state_next = cancel ? DRAIN : WAIT;
                else if (cancel) state_next = IDLE;
            end
            WAIT: begin
                if (data_ok)     state_next = cancel ? IDLE : RESP;
                else if (cancel) state_next = DRAIN;
            end
            DRAIN: if (data_ok) state_next = IDLE;
            RESP:  if (cancel || resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the access on acceptance and capture the result on completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            size_reg  <= 2'd0;
            addr_reg  <= '0;
            strb_reg  <= 4'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            wr_reg    <= req_wr;
            uns_reg   <= req_op[2];
            size_reg  <= in_size;
            addr_reg  <= req_addr;
            strb_reg  <= req_wr ? in_strb : 4'b1111;
            wdata_reg <= req_wr ? in_wdata : 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= misaligned;
        end else if ((state_reg == WAIT) && data_ok && !cancel) begin
            rdata_reg <= wr_reg ? 32'd0 : load_ext;
        end
    end

    assign req_ready  = resetn && (state_reg == IDLE);
    assign data_req   = (state_reg == REQ);
    assign data_wr    = wr_reg;
    assign data_size  = size_reg;
    assign data_strb  = strb_reg;
    assign data_addr  = addr_reg;
    assign data_wdata = wdata_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed accesses with a scoreboard queue of expected
// responses, drained by a monitor on the falling clock edge.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        cancel = 1'b0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_strb;
    logic [31:0] data_addr, data_wdata;
    logic [31:0] data_rdata = 32'd0;
    logic        data_raddr_ok = 1'b0, data_waddr_ok = 1'b0;
    logic        data_rdata_ok = 1'b0, data_wdata_ok = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    pass_cnt = 0;
    int    chk_cnt  = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .cancel(cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_strb(data_strb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_raddr_ok(data_raddr_ok),
        .data_waddr_ok(data_waddr_ok), .data_rdata_ok(data_rdata_ok),
        .data_wdata_ok(data_wdata_ok),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every accepted response is compared with the queue head.
    always @(negedge clk) begin
        if (resetn && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, mon_e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
                $display("resp: rdata=0x%08h err=%0d (expected 0x%08h err=%0d)",
                         resp_rdata, resp_err, mon_e.rdata, mon_e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Present one request for a single cycle; called at posedge+1.
    task automatic accept_req(input logic wr, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata);
        check("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("return_idle", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int adly,
                       input logic [1:0] e_size, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata, input logic [31:0] e_r, input logic e_err);
        int held = 0;
        exp_q.push_back({e_r, e_err});
        accept_req(wr, op, addr, wdata);
        if (e_err) begin
            check("no_bus_req", {31'd0, data_req}, 32'd0);
        end else begin
            check("data_size", {30'd0, data_size}, {30'd0, e_size});
            check("data_strb", {28'd0, data_strb}, {28'd0, e_strb});
            check("data_wdata", data_wdata, e_wdata);
            check("data_addr", data_addr, addr);
            check("data_wr", {31'd0, data_wr}, {31'd0, wr});
            for (int i = 0; i < adly; i++) begin
                if (data_req) held++;
                check("strb_stable", {28'd0, data_strb}, {28'd0, e_strb});
                @(posedge clk); #1;
            end
            if (data_req) held++;
            check("req_hold_cycles", held, adly + 1);
            if (wr) data_waddr_ok = 1'b1; else data_raddr_ok = 1'b1;
            @(posedge clk); #1;
            data_waddr_ok = 1'b0; data_raddr_ok = 1'b0;
            check("req_drop", {31'd0, data_req}, 32'd0);
            check("no_early_resp", {31'd0, resp_valid}, 32'd0);
            data_rdata = rdata;
            if (wr) data_wdata_ok = 1'b1; else data_rdata_ok = 1'b1;
            @(posedge clk); #1;
            data_wdata_ok = 1'b0; data_rdata_ok = 1'b0;
        end
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        wait_idle();
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_data_req", {31'd0, data_req}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_strb", {28'd0, data_strb}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        //   wr    op      addr          wdata         rdata       dly size strb     wdata_bus     resp          err
        run(1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 2'd0, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0);
        run(1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 2'd1, 4'b1111, 32'h0,        32'h0000_BEEF, 1'b0);
        run(1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 2'd1, 4'b1111, 32'h0,        32'hFFFF_BEEF, 1'b0);
        run(1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h0,        4, 2'd1, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
        run(1'b0, 3'b010, 32'h0000_4001, 32'h0,        32'h0,        0, 2'd2, 4'b1111, 32'h0,        32'h0,        1'b1);
        run(1'b1, 3'b000, 32'h0000_5001, 32'h1234_5677, 32'h0,        1, 2'd0, 4'b0010, 32'h7777_7777, 32'h0,        1'b0);
        run(1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,        0, 2'd2, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);
        run(1'b0, 3'b100, 32'h0000_7001, 32'h0,        32'h0000_9A00, 0, 2'd0, 4'b1111, 32'h0,        32'h0000_009A, 1'b0);
        run(1'b0, 3'b010, 32'h0000_8004, 32'h0,        32'hCAFE_F00D, 2, 2'd2, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0);
        run(1'b0, 3'b001, 32'h0000_9001, 32'h0,        32'h0,        0, 2'd1, 4'b1111, 32'h0,        32'h0,        1'b1);
        run(1'b0, 3'b011, 32'h0000_A002, 32'h0,        32'h0,        0, 2'd2, 4'b1111, 32'h0,        32'h0,        1'b1);
        run(1'b0, 3'b011, 32'h0000_A004, 32'h0,        32'h89AB_CDEF, 0, 2'd2, 4'b1111, 32'h0,        32'h89AB_CDEF, 1'b0);
        run(1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 2'd0, 4'b1111, 32'h0,        32'h0000_007F, 1'b0);

        // Cancel in WAIT: drain the owed data phase, produce no response
        accept_req(1'b0, 3'b010, 32'h0000_C000, 32'h0);
        data_raddr_ok = 1'b1;
        @(posedge clk); #1;
        data_raddr_ok = 1'b0;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_ready_low", {31'd0, req_ready}, 32'd0);
            check("drain_no_resp", {31'd0, resp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        data_rdata = 32'h5555_AAAA;
        data_rdata_ok = 1'b1;
        @(posedge clk); #1;
        data_rdata_ok = 1'b0;
        check("drain_done_ready", {31'd0, req_ready}, 32'd1);
        check("drain_done_no_resp", {31'd0, resp_valid}, 32'd0);
        $display("cancel in WAIT: drained");

        // Cancel in REQ before address accepted
        accept_req(1'b0, 3'b010, 32'h0000_D000, 32'h0);
        check("cancel_req_active", {31'd0, data_req}, 32'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_req_idle", {31'd0, req_ready}, 32'd1);
        check("cancel_req_no_bus", {31'd0, data_req}, 32'd0);
        check("cancel_req_no_resp", {31'd0, resp_valid}, 32'd0);
        $display("cancel in REQ: aborted");

        // Response held under back-pressure, then async reset mid-RESP
        resp_ready = 1'b0;
        accept_req(1'b0, 3'b010, 32'h0000_B000, 32'h0);
        data_raddr_ok = 1'b1;
        @(posedge clk); #1;
        data_raddr_ok = 1'b0;
        data_rdata = 32'h1122_3344;
        data_rdata_ok = 1'b1;
        @(posedge clk); #1;
        data_rdata_ok = 1'b0;
        data_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_resp_rdata", resp_rdata, 32'h1122_3344);
            @(posedge clk); #1;
        end
        #3 resetn = 1'b0;
        #1;
        check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("async_rst_resp_rdata", resp_rdata, 32'd0);
        check("async_rst_data_addr", data_addr, 32'd0);
        check("async_rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        $display("reset mid-RESP: outputs cleared");

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
